alert_esc_event_decoder: RTL and testbench

- Passive, synthesizable decoder for NumAlerts alert channels and NumEsc escalation channels, in parallel.
- Taps differential alert_tx/alert_rx and esc_tx/esc_rx wires and turns them into registered event pulses and per-channel saturating counters.
- Supports alert handshakes, pings, escalations and integrity errors.
- Sits beside alert_handler-class logic; used for on-chip event logging and as a bind-able reference decoder for DV scoreboards.

---
 rtl/alert_esc_event_decoder_pkg.sv | 38 +++
 rtl/alert_esc_event_decoder_hs.sv | 133 +++++++++++++
 rtl/alert_esc_event_decoder.sv | 108 ++++++++++
 tb/tb_alert_esc_event_decoder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alert_esc_event_decoder_pkg.sv
// ============================================================================
// Module   : alert_esc_event_decoder_pkg
// Purpose  : Shared types and wire-packing indices for the alert/escalation
//            event decoder. Optional feature macro used by the decoder:
//            ALERT_ESC_EVENT_DECODER_TIMEOUT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alert_esc_event_decoder_pkg;

    // Four-phase alert handshake progress, one instance per alert channel
    typedef enum logic [1:0] {
        Idle         = 2'd0,
        WaitAck      = 2'd1,
        WaitDeassert = 2'd2,
        WaitAckLow   = 2'd3
    } alert_hs_state_e;

    // Bit positions inside one channel's alert_tx slice {alert_p, alert_n}
    localparam int unsigned AlertPIdx = 1;
    localparam int unsigned AlertNIdx = 0;

    // Bit positions inside one channel's alert_rx slice {ping_p, ping_n, ack_p, ack_n}
    localparam int unsigned PingPIdx  = 3;
    localparam int unsigned PingNIdx  = 2;
    localparam int unsigned AckPIdx   = 1;
    localparam int unsigned AckNIdx   = 0;

    // Bit positions inside one channel's esc_tx {esc_p, esc_n} / esc_rx {resp_p, resp_n}
    localparam int unsigned EscPIdx   = 1;
    localparam int unsigned EscNIdx   = 0;
    localparam int unsigned RespPIdx  = 1;
    localparam int unsigned RespNIdx  = 0;

endpackage

`default_nettype wire

// File: rtl/alert_esc_event_decoder_hs.sv
// ============================================================================
// Module   : alert_hs_decoder
// Purpose  : One passive alert channel decoder: four-phase handshake FSM,
//            ping toggle detector, integrity checking and a saturating
//            handshake counter. With ALERT_ESC_EVENT_DECODER_TIMEOUT_EN
//            defined, a wait counter aborts handshakes stuck in a Wait state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alert_hs_decoder
    import alert_esc_event_decoder_pkg::*;
#(
    parameter int unsigned CntW          = 8,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      alert_tx,
    input  logic [3:0]      alert_rx,
    output logic            hs_event,
    output logic            ping,
    output logic            int_err,
    output logic [CntW-1:0] cnt
);

    logic alert_p, alert_n, ping_p, ping_n, ack_p, ack_n;
    logic pair_ok;
    logic done;
    logic timeout;
    logic event_d, err_d, ping_d;
    logic ping_prev;
    alert_hs_state_e state_q, hs_next, state_d;

    assign alert_p = alert_tx[AlertPIdx];
    assign alert_n = alert_tx[AlertNIdx];
    assign ping_p  = alert_rx[PingPIdx];
    assign ping_n  = alert_rx[PingNIdx];
    assign ack_p   = alert_rx[AckPIdx];
    assign ack_n   = alert_rx[AckNIdx];

    // Both pairs complementary; an X/Z makes this unknown and the if/else
    // structures below then fall into their error branches.
    assign pair_ok = (alert_p ^ alert_n) & (ack_p ^ ack_n);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: at most one handshake phase per cycle, integrity loss aborts
    always_comb begin
        hs_next = state_q;
        done    = 1'b0;
        if (pair_ok) begin
            case (state_q)
                Idle:         if (alert_p)  hs_next = WaitAck;
                WaitAck:      if (ack_p)    hs_next = WaitDeassert;
                WaitDeassert: if (!alert_p) hs_next = WaitAckLow;
                WaitAckLow: begin
                    if (!ack_p) begin
                        hs_next = Idle;
                        done    = 1'b1;
                    end
                end
                default:      hs_next = Idle;
            endcase
        end else begin
            hs_next = Idle;
        end
    end

    assign state_d = timeout ? Idle : hs_next;

`ifdef ALERT_ESC_EVENT_DECODER_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TimeoutCycles + 1);

    logic [WaitW-1:0] wait_cnt;

    // Expires on the cycle the count would reach TimeoutCycles while parked
    assign timeout = (state_q != Idle) && (hs_next == state_q) &&
                     (wait_cnt == WaitW'(TimeoutCycles - 1));

    // Wait counter: restarts on every transition, counts while parked in Wait*
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state_d != state_q) || (state_q == Idle)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Output decode: event on handshake completion, error on integrity loss or timeout
    always_comb begin
        event_d = done;
        err_d   = 1'b1;
        if (pair_ok) begin
            err_d = timeout;
        end
        ping_d  = (ping_p ^ ping_prev) & (ping_p ^ ping_n);
    end

    // Registered outputs, ping history and saturating event counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_event  <= 1'b0;
            int_err   <= 1'b0;
            ping      <= 1'b0;
            ping_prev <= 1'b0;
            cnt       <= '0;
        end else begin
            hs_event  <= event_d;
            int_err   <= err_d;
            ping      <= ping_d;
            ping_prev <= ping_p;
            if (event_d && (cnt != {CntW{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alert_esc_event_decoder.sv
// ============================================================================
// Module   : alert_esc_event_decoder
// Purpose  : Passive tap on differential alert and escalation wires. Emits
//            registered event pulses, integrity errors and saturating
//            per-channel counters. Optional feature macro:
//            ALERT_ESC_EVENT_DECODER_TIMEOUT_EN (alert handshake wait timeout)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alert_esc_event_decoder
    import alert_esc_event_decoder_pkg::*;
#(
    parameter int unsigned NumAlerts     = 4,
    parameter int unsigned NumEsc        = 4,
    parameter int unsigned CntW          = 8,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*NumAlerts-1:0]    alert_tx_i,
    input  logic [4*NumAlerts-1:0]    alert_rx_i,
    input  logic [2*NumEsc-1:0]       esc_tx_i,
    input  logic [2*NumEsc-1:0]       esc_rx_i,
    output logic [NumAlerts-1:0]      alert_event_o,
    output logic [NumAlerts-1:0]      alert_ping_o,
    output logic [NumAlerts-1:0]      alert_int_err_o,
    output logic [CntW*NumAlerts-1:0] alert_cnt_o,
    output logic [NumEsc-1:0]         esc_ping_o,
    output logic [NumEsc-1:0]         esc_active_o,
    output logic [NumEsc-1:0]         esc_int_err_o,
    output logic [CntW*NumEsc-1:0]    esc_cycles_o
);

    for (genvar a = 0; a < NumAlerts; a++) begin : g_alert
        alert_hs_decoder #(
            .CntW          (CntW),
            .TimeoutCycles (TimeoutCycles)
        ) u_alert_hs_decoder (
            .clk      (clk),
            .rst_n    (rst_n),
            .alert_tx (alert_tx_i[2*a +: 2]),
            .alert_rx (alert_rx_i[4*a +: 4]),
            .hs_event (alert_event_o[a]),
            .ping     (alert_ping_o[a]),
            .int_err  (alert_int_err_o[a]),
            .cnt      (alert_cnt_o[CntW*a +: CntW])
        );
    end

    for (genvar e = 0; e < NumEsc; e++) begin : g_esc
        logic            esc_p, esc_n, resp_p, resp_n;
        logic            active_s;
        logic            prev_active;
        logic            run_active;
        logic            ping_q;
        logic            err_q;
        logic [CntW-1:0] run_len;

        assign esc_p  = esc_tx_i[2*e + EscPIdx];
        assign esc_n  = esc_tx_i[2*e + EscNIdx];
        assign resp_p = esc_rx_i[2*e + RespPIdx];
        assign resp_n = esc_rx_i[2*e + RespNIdx];

        // Unknown inputs evaluate false in the if below, i.e. non-active
        assign active_s = esc_p & ~esc_n;

        // Run tracking: length, level-active from 2nd sample, single-cycle ping, integrity
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_active <= 1'b0;
                run_active  <= 1'b0;
                ping_q      <= 1'b0;
                err_q       <= 1'b0;
                run_len     <= '0;
            end else begin
                if (active_s) begin
                    prev_active <= 1'b1;
                    run_active  <= prev_active;
                    ping_q      <= 1'b0;
                    if (!prev_active) begin
                        run_len <= CntW'(1);
                    end else if (run_len != {CntW{1'b1}}) begin
                        run_len <= run_len + 1'b1;
                    end
                end else begin
                    prev_active <= 1'b0;
                    run_active  <= 1'b0;
                    // run_active still low here means the run lasted one sample
                    ping_q      <= prev_active & ~run_active;
                end
                if ((esc_p ^ esc_n) && (!run_active || (resp_p ^ resp_n))) begin
                    err_q <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end

        assign esc_ping_o[e]                = ping_q;
        assign esc_active_o[e]              = run_active;
        assign esc_int_err_o[e]             = err_q;
        assign esc_cycles_o[CntW*e +: CntW] = run_len;
    end

endmodule

`default_nettype wire

// File: tb/tb_alert_esc_event_decoder.sv
// ============================================================================
// Module   : tb_alert_esc_event_decoder
// Purpose  : Self-checking bench for alert_esc_event_decoder. Expected output
//            vectors are queued as stimulus is applied and compared after the
//            following clock edge. Honours ALERT_ESC_EVENT_DECODER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alert_esc_event_decoder;

    localparam int NA  = 4;
    localparam int NE  = 4;
    localparam int CW  = 8;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2*NA-1:0] alert_tx;
    logic [4*NA-1:0] alert_rx;
    logic [2*NE-1:0] esc_tx;
    logic [2*NE-1:0] esc_rx;
    logic [NA-1:0]   alert_event, alert_ping, alert_int_err;
    logic [CW*NA-1:0] alert_cnt;
    logic [NE-1:0]   esc_ping, esc_active, esc_int_err;
    logic [CW*NE-1:0] esc_cycles;

    alert_esc_event_decoder #(
        .NumAlerts(NA), .NumEsc(NE), .CntW(CW), .TimeoutCycles(TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alert_tx_i      (alert_tx),
        .alert_rx_i      (alert_rx),
        .esc_tx_i        (esc_tx),
        .esc_rx_i        (esc_rx),
        .alert_event_o   (alert_event),
        .alert_ping_o    (alert_ping),
        .alert_int_err_o (alert_int_err),
        .alert_cnt_o     (alert_cnt),
        .esc_ping_o      (esc_ping),
        .esc_active_o    (esc_active),
        .esc_int_err_o   (esc_int_err),
        .esc_cycles_o    (esc_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NA-1:0]    ev;
        logic [NA-1:0]    ping;
        logic [NA-1:0]    aerr;
        logic [CW*NA-1:0] acnt;
        logic [NE-1:0]    eping;
        logic [NE-1:0]    eact;
        logic [NE-1:0]    eerr;
        logic [CW*NE-1:0] ecyc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state
    int   m_st[NA];
    int   m_cnt[NA];
    int   m_wait[NA];
    logic m_pprev[NA];
    logic m_prev[NE];
    logic m_eact[NE];
    int   m_run[NE];

    // Tallies of DUT pulses for directed checks
    int ping2_pulses, err1_pulses, eping0_pulses, eact0_cycles, err0_pulses;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NA; c++) begin
            m_st[c] = 0; m_cnt[c] = 0; m_wait[c] = 0; m_pprev[c] = 1'b0;
        end
        for (int c = 0; c < NE; c++) begin
            m_prev[c] = 1'b0; m_eact[c] = 1'b0; m_run[c] = 0;
        end
    endtask

    // Spec-level prediction of the outputs after the next edge
    task automatic model(output exp_t e);
        logic ap, an, pp, pn, kp, kn, aerr, ev, ep, en, rp, rn, act;
        int   nxt;
        e = '0;
        for (int c = 0; c < NA; c++) begin
            {ap, an} = alert_tx[2*c +: 2];
            {pp, pn, kp, kn} = alert_rx[4*c +: 4];
            aerr = (ap == an) || (kp == kn);
            ev   = 1'b0;
            nxt  = 0;
            if (!aerr) begin
                nxt = m_st[c];
                case (m_st[c])
                    0: if (ap)  nxt = 1;
                    1: if (kp)  nxt = 2;
                    2: if (!ap) nxt = 3;
                    3: if (!kp) begin nxt = 0; ev = 1'b1; end
                    default: nxt = 0;
                endcase
            end
`ifdef ALERT_ESC_EVENT_DECODER_TIMEOUT_EN
            if (nxt != m_st[c]) begin
                m_wait[c] = 0;
            end else if (m_st[c] != 0) begin
                if (m_wait[c] == TMO - 1) begin
                    nxt = 0; aerr = 1'b1; m_wait[c] = 0;
                end else begin
                    m_wait[c]++;
                end
            end
`endif
            m_st[c] = nxt;
            if (ev && m_cnt[c] < 255) m_cnt[c]++;
            e.ping[c] = (pp != m_pprev[c]) && (pp != pn);
            m_pprev[c] = pp;
            e.ev[c]   = ev;
            e.aerr[c] = aerr;
            e.acnt[CW*c +: CW] = CW'(m_cnt[c]);
        end
        for (int c = 0; c < NE; c++) begin
            {ep, en} = esc_tx[2*c +: 2];
            {rp, rn} = esc_rx[2*c +: 2];
            act = ep && !en;
            e.eerr[c]  = (ep == en) || (m_eact[c] && (rp == rn));
            e.eping[c] = !act && m_prev[c] && !m_eact[c];
            if (act) m_run[c] = m_prev[c] ? ((m_run[c] == 255) ? 255 : m_run[c] + 1) : 1;
            m_eact[c] = act && m_prev[c];
            m_prev[c] = act;
            e.eact[c] = m_eact[c];
            e.ecyc[CW*c +: CW] = CW'(m_run[c]);
        end
    endtask

    // Apply current inputs for one cycle and score the registered result
    task automatic step();
        exp_t e;
        model(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("alert_event",   64'(alert_event),   64'(e.ev));
        check("alert_ping",    64'(alert_ping),    64'(e.ping));
        check("alert_int_err", 64'(alert_int_err), 64'(e.aerr));
        check("alert_cnt",     64'(alert_cnt),     64'(e.acnt));
        check("esc_ping",      64'(esc_ping),      64'(e.eping));
        check("esc_active",    64'(esc_active),    64'(e.eact));
        check("esc_int_err",   64'(esc_int_err),   64'(e.eerr));
        check("esc_cycles",    64'(esc_cycles),    64'(e.ecyc));
        ping2_pulses  += int'(alert_ping[2]);
        err1_pulses   += int'(alert_int_err[1]);
        err0_pulses   += int'(alert_int_err[0]);
        eping0_pulses += int'(esc_ping[0]);
        eact0_cycles  += int'(esc_active[0]);
    endtask

    task automatic all_idle();
        alert_tx = {NA{2'b01}};
        alert_rx = {NA{4'b0101}};
        esc_tx   = {NE{2'b01}};
        esc_rx   = {NE{2'b01}};
    endtask

    task automatic set_alert(input int c, input logic [1:0] v); alert_tx[2*c +: 2]   = v; endtask
    task automatic set_ack  (input int c, input logic [1:0] v); alert_rx[4*c +: 2]   = v; endtask
    task automatic set_ping (input int c, input logic [1:0] v); alert_rx[4*c+2 +: 2] = v; endtask
    task automatic set_esc  (input int c, input logic [1:0] v); esc_tx[2*c +: 2]     = v; endtask
    task automatic set_resp (input int c, input logic [1:0] v); esc_rx[2*c +: 2]     = v; endtask

    task automatic handshake(input int c, input int hold);
        set_alert(c, 2'b10); repeat (hold) step();
        set_ack(c, 2'b10);   repeat (hold) step();
        set_alert(c, 2'b01); repeat (hold) step();
        set_ack(c, 2'b01);   repeat (hold) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_event"},   64'(alert_event),   64'd0);
        check({tag, "_ping"},    64'(alert_ping),    64'd0);
        check({tag, "_aerr"},    64'(alert_int_err), 64'd0);
        check({tag, "_acnt"},    64'(alert_cnt),     64'd0);
        check({tag, "_eping"},   64'(esc_ping),      64'd0);
        check({tag, "_eact"},    64'(esc_active),    64'd0);
        check({tag, "_eerr"},    64'(esc_int_err),   64'd0);
        check({tag, "_ecyc"},    64'(esc_cycles),    64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] byte_v;
        rst_n = 1'b0;
        all_idle();
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();

        // Ch0 clean handshake, two cycles per phase
        handshake(0, 2);
        step();
        byte_v = alert_cnt[7:0];
        check("hs0_cnt", 64'(byte_v), 64'd1);
        check("hs0_others", 64'(alert_cnt[CW*NA-1:CW]), 64'd0);

        // Ch2 pings: three toggles five cycles apart
        ping2_pulses = 0;
        for (int t = 0; t < 3; t++) begin
            set_ping(2, (t % 2 == 0) ? 2'b10 : 2'b01);
            repeat (5) step();
        end
        check("ping2_pulses", 64'(ping2_pulses), 64'd3);

        // Ch1 integrity error while in WaitAck forces Idle with no event
        err1_pulses = 0;
        set_alert(1, 2'b10); repeat (2) step();
        set_alert(1, 2'b11); repeat (3) step();
        set_alert(1, 2'b01); step();
        set_ack(1, 2'b10);   step();
        set_ack(1, 2'b01);   repeat (2) step();
        check("err1_pulses", 64'(err1_pulses), 64'd3);
        byte_v = alert_cnt[CW +: CW];
        check("err1_cnt", 64'(byte_v), 64'd0);

        // Esc ch0: one-cycle run then five-cycle run
        eping0_pulses = 0;
        eact0_cycles  = 0;
        set_esc(0, 2'b10); step();
        set_esc(0, 2'b01); repeat (2) step();
        set_esc(0, 2'b10); repeat (5) step();
        set_esc(0, 2'b01); repeat (3) step();
        check("esc0_ping", 64'(eping0_pulses), 64'd1);
        check("esc0_active", 64'(eact0_cycles), 64'd4);
        byte_v = esc_cycles[7:0];
        check("esc0_cycles", 64'(byte_v), 64'd5);

        // Esc integrity: resp error while active, esc_p==esc_n, resp ignored when inactive
        set_esc(1, 2'b10); repeat (3) step();
        set_resp(1, 2'b11); step();
        set_resp(1, 2'b01); set_esc(1, 2'b11); step();
        set_esc(1, 2'b01); step();
        set_resp(2, 2'b11); step();
        set_resp(2, 2'b01); step();

        // Ch3 counter saturation
        for (int i = 0; i < 300; i++) handshake(3, 1);
        step();
        byte_v = alert_cnt[3*CW +: CW];
        check("cnt3_sat", 64'(byte_v), 64'd255);

`ifdef ALERT_ESC_EVENT_DECODER_TIMEOUT_EN
        // Ch0 stuck in WaitAck: one timeout pulse 64 cycles after entry
        set_alert(0, 2'b10); step();
        err0_pulses = 0;
        for (int j = 1; j <= TMO; j++) begin
            step();
            if (j == TMO) check("tmo_pulse", 64'(alert_int_err[0]), 64'd1);
        end
        check("tmo_count", 64'(err0_pulses), 64'd1);
        set_alert(0, 2'b01); repeat (2) step();
`endif

        // Asynchronous reset in the middle of activity
        set_alert(0, 2'b10); set_esc(0, 2'b10); repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        all_idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
